stream_arbiter: RTL and testbench
=================================

Name: stream_arbiter

Overview:
- Shares one downstream valid/ready stream sink between N upstream stream sources.
- Round-robin grant with burst limit; the granted source owns the sink until it has done BURST transfers or drops vld.
- Sits between stream_source instances and a single stream_drain or DSP stage.
- Data path is combinational through a registered grant; no data storage.

Parameters:
- N, 4, number of requesting source streams (2..16)
- DW, 16, data width per stream
- BURST, 8, maximum transfers per grant (1..65535)

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- s_vld  input  N  per-source valid
- s_dat  input  N*DW  per-source data; source i occupies bits [i*DW +: DW]
- s_rdy  output  N  per-source ready
- m_vld  output  1  merged stream valid
- m_dat  output  DW  merged stream data
- m_rdy  input  1  sink ready
- gnt  output  N  one-hot current grant, all-zero when idle
- busy  output  1  high while a grant is held

Behaviour:
- Reset value of every output:
  - Registered outputs: gnt=0, busy=0, burst counter=0, last-grant pointer=N-1 (so source 0 wins first).
  - Combinational outputs with gnt=0: m_vld=0, m_dat=0, s_rdy=0.
- Reset is asynchronous: asserting rst mid-burst drops the grant immediately. Any in-flight word not handshaken is not transferred.
- Transfer definition: a transfer occurs when m_vld & m_rdy in a cycle.
- State IDLE (busy=0):
  - If any s_vld is set, select the first requester searching from (last+1) mod N upward with wrap.
  - Set gnt to that requester, update last, clear the counter, go to BUSY.
  - Arbitration latency is 1 cycle: no transfer happens in the IDLE cycle.
- State BUSY (busy=1), granted index g:
  - m_vld = s_vld[g], m_dat = s_dat[g], s_rdy[g] = m_rdy; all other s_rdy = 0.
  - Counter increments on each transfer.
- BUSY -> IDLE, occurs on the next edge when either:
  - a transfer happens with counter == BURST-1, or
  - s_vld[g] == 0 in a BUSY cycle.
- After release, one IDLE cycle always follows, even if requests are pending. Back-to-back bursts from different sources therefore have exactly 1 bubble cycle.
- Simultaneous events:
  - Burst-limit transfer and another source requesting: release, then round-robin from g+1 in IDLE.
  - Only source g still requesting: it is re-granted after the bubble.
- m_rdy held low: the grant is held indefinitely; the counter does not advance.
- Handshake: m_vld never depends on m_rdy. m_dat is stable while m_vld & !m_rdy, provided the source obeys the stream rules.
- Counter width: clog2(BURST+1); no wrap within a grant.

Optional Feature:
- Macro: STREAM_ARB_FIXPRIO_EN.
- Defined: fixed priority; the lowest-index active requester always wins in IDLE, and the last pointer is unused. The burst limit and release rules are unchanged.
- Undefined: round-robin as above.

Decomposition:
- Package stream_pkg: localparam function clog2, and the state encoding constants ST_IDLE / ST_BUSY.
- One sub-module: stream_arb_pick. It is a combinational N-bit request plus start index to one-hot winner, with rotate-priority logic. The fixed-priority variant forces start index 0.
- The top holds the FSM, counter and muxes.

Test Plan:
1. Single requester: N=4, BURST=8, s_vld=4'b0001 constant, m_rdy=1 -> gnt=0001 from cycle 1 after reset release; 8 transfers, then 1 idle cycle, re-grant; 16 transfers in 18 cycles.
2. All requesting, m_rdy=1, BURST=2 -> grant order 0,1,2,3,0; each burst is exactly 2 words; m_dat matches the granted source.
3. Source drops vld: source 1 granted, s_vld[1] deasserted after 3 transfers -> busy falls next edge; source 2 granted after the bubble; counter restarts at 0.
4. Backpressure: m_rdy=0 for 5 cycles mid-burst -> m_vld and m_dat held; gnt unchanged; no counter increment; all non-granted s_rdy=0.
5. Reset mid-burst: rst asserted async after 4 transfers -> gnt, busy, m_vld go 0 immediately; after release source 0 wins first.
6. Random: all sources randomly toggling vld and m_rdy (50% each), 1000 transfers -> per-source data order preserved; no transfer while gnt=0; no burst exceeds BURST.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared types and helpers for the stream arbiter: ceil-log2 for sizing
// index/counter fields, and the arbiter state encoding.
package stream_pkg;

  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin
    end
    return r;
  endfunction

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/stream_arbiter_if.sv
// Bundle of the N upstream source streams and the one merged downstream stream.
// master: the arbiter's view. slave: the sources'/sink's view.
interface stream_arbiter_if #(
  parameter int N  = 4,
  parameter int DW = 16
);
  // Valid/ready: a word moves in any cycle where vld & rdy are both high.
  // A producer holding vld keeps its data stable until accepted; vld never
  // depends on rdy in the same cycle.
  logic [N-1:0]    s_vld;
  logic [N*DW-1:0] s_dat;
  logic [N-1:0]    s_rdy;
  logic            m_vld;
  logic [DW-1:0]   m_dat;
  logic            m_rdy;

  modport master (
    input  s_vld, s_dat, m_rdy,
    output s_rdy, m_vld, m_dat
  );

  modport slave (
    output s_vld, s_dat, m_rdy,
    input  s_rdy, m_vld, m_dat
  );
endinterface

// File: rtl/stream_arb_pick.sv
// Rotating-priority picker: first set request found from index start upward,
// wrapping at N, returned as a one-hot vector and its index.
module stream_arb_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  win,
  output logic [IW-1:0] win_idx
);

  logic          found;
  logic [IW:0]   j;
  logic [IW-1:0] jj;

  always_comb begin
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    j       = '0;
    jj      = '0;
    for (int i = 0; i < N; i++) begin
      j = {1'b0, start} + (IW+1)'(i);
      if (j >= (IW+1)'(N)) begin
        j = j - (IW+1)'(N);
      end
      jj = j[IW-1:0];
      if (!found && req[jj]) begin
        win[jj] = 1'b1;
        win_idx = jj;
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_arbiter.sv
// N-to-1 valid/ready stream arbiter, round-robin with a per-grant burst limit.
// Define STREAM_ARB_FIXPRIO_EN for fixed priority (lowest index wins).
module stream_arbiter
  import stream_pkg::*;
#(
  parameter int N     = 4,
  parameter int DW    = 16,
  parameter int BURST = 8
) (
  input  logic                clk,
  input  logic                rst,
  stream_arbiter_if.master    bus,
  output logic [N-1:0]        gnt,
  output logic                busy,
  output arb_state_t          dbg_state
);

  localparam int IW = clog2(N);
  localparam int CW = clog2(BURST + 1);

  arb_state_t    state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [IW-1:0] last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [IW-1:0] start;
  logic [N-1:0]  win;
  logic [IW-1:0] win_idx;
  logic          m_vld_i;
  logic [DW-1:0] m_dat_i;
  logic          xfer;

`ifdef STREAM_ARB_FIXPRIO_EN
  assign start = '0;
`else
  assign start = (last_q == IW'(N-1)) ? '0 : last_q + IW'(1);
`endif

  stream_arb_pick #(.N(N), .IW(IW)) u_pick (
    .req     (bus.s_vld),
    .start   (start),
    .win     (win),
    .win_idx (win_idx)
  );

  // gnt_q is all-zero in IDLE, so the one-hot mux yields zeros there.
  always_comb begin
    m_vld_i = 1'b0;
    m_dat_i = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_q[i]) begin
        m_vld_i = bus.s_vld[i];
        m_dat_i = bus.s_dat[i*DW +: DW];
      end
    end
  end

  assign bus.m_vld = m_vld_i;
  assign bus.m_dat = m_dat_i;
  assign bus.s_rdy = gnt_q & {N{bus.m_rdy}};
  assign xfer      = m_vld_i & bus.m_rdy;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (|win) begin
          state_d = ST_BUSY;
          gnt_d   = win;
          last_d  = win_idx;
          cnt_d   = '0;
        end
      end
      ST_BUSY: begin
        // Release on source drop or the final word of the burst; IDLE then
        // always costs one bubble before the next grant.
        if (!m_vld_i || (xfer && cnt_q == CW'(BURST-1))) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end else if (xfer) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      last_q  <= IW'(N-1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign busy      = (state_q == ST_BUSY);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_stream_arbiter.sv
// Directed and random checks of stream_arbiter, BURST=8 and BURST=2 instances
// sharing one set of source/sink stimulus.
module tb_stream_arbiter;
  import stream_pkg::*;

  localparam int N  = 4;
  localparam int DW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    s_vld;
  logic [N*DW-1:0] s_dat;
  logic            m_rdy;
  logic            sel;      // 0: BURST=8 instance, 1: BURST=2 instance

  stream_arbiter_if #(.N(N), .DW(DW)) if8 ();
  stream_arbiter_if #(.N(N), .DW(DW)) if2 ();

  assign if8.s_vld = s_vld;
  assign if8.s_dat = s_dat;
  assign if8.m_rdy = m_rdy;
  assign if2.s_vld = s_vld;
  assign if2.s_dat = s_dat;
  assign if2.m_rdy = m_rdy;

  logic [N-1:0] gnt8, gnt2;
  logic         busy8, busy2;
  arb_state_t   st8, st2;

  stream_arbiter #(.N(N), .DW(DW), .BURST(8)) u_arb8 (
    .clk(clk), .rst(rst), .bus(if8), .gnt(gnt8), .busy(busy8), .dbg_state(st8)
  );
  stream_arbiter #(.N(N), .DW(DW), .BURST(2)) u_arb2 (
    .clk(clk), .rst(rst), .bus(if2), .gnt(gnt2), .busy(busy2), .dbg_state(st2)
  );

  logic [N-1:0]  cur_gnt, cur_s_rdy;
  logic          cur_busy, cur_m_vld;
  logic [DW-1:0] cur_m_dat;
  int            cur_burst;
  assign cur_gnt   = sel ? gnt2 : gnt8;
  assign cur_busy  = sel ? busy2 : busy8;
  assign cur_s_rdy = sel ? if2.s_rdy : if8.s_rdy;
  assign cur_m_vld = sel ? if2.m_vld : if8.m_vld;
  assign cur_m_dat = sel ? if2.m_dat : if8.m_dat;
  assign cur_burst = sel ? 2 : 8;

  // ---------------- source model: word = {source, sequence} ----------------
  logic [11:0] src_seq [N];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) src_seq[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++)
        if (s_vld[i] && cur_s_rdy[i]) src_seq[i] <= src_seq[i] + 12'd1;
    end
  end

  always_comb begin
    s_dat = '0;
    for (int i = 0; i < N; i++) s_dat[i*DW +: DW] = {4'(i), src_seq[i]};
  end

  function automatic logic [DW-1:0] wd(input int src, input int seq);
    return {4'(src), 12'(seq)};
  endfunction

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q[$];
  int mode = 0;              // 0 off, 1 directed queue, 2 random properties
  int n_xfer;
  int run_len;
  int g_idx;
  logic [11:0] exp_seq [N];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      n_xfer  = 0;
      run_len = 0;
      for (int i = 0; i < N; i++) exp_seq[i] = '0;
    end else if (mode == 1) begin
      if (cur_m_vld && m_rdy) begin
        n_xfer++;
        if (exp_q.size() == 0) check("xfer_extra", cur_m_dat, 32'hffff_ffff);
        else check("xfer_dat", cur_m_dat, exp_q.pop_front());
      end
    end else if (mode == 2) begin
      if (cur_gnt == '0) begin
        run_len = 0;
        check("rnd_idle_mvld", cur_m_vld, 0);
      end else if (cur_m_vld && m_rdy) begin
        g_idx = 0;
        for (int i = 0; i < N; i++) if (cur_gnt[i]) g_idx = i;
        n_xfer++;
        run_len++;
        check("rnd_onehot", $onehot(cur_gnt), 1);
        check("rnd_src", cur_m_dat[15:12], g_idx);
        check("rnd_order", cur_m_dat[11:0], exp_seq[g_idx]);
        exp_seq[g_idx] = exp_seq[g_idx] + 12'd1;
        check("rnd_burst_len", run_len <= cur_burst, 1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    next_cycle();
    mode  = 0;
    rst   = 1'b1;
    s_vld = '0;
    m_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    s_vld = '0;
    m_rdy = 1'b0;
    sel   = 1'b0;

    // Reset state of both instances
    do_reset();
    @(negedge clk);
    check("rst_gnt8", gnt8, 0);
    check("rst_busy8", busy8, 0);
    check("rst_state8", st8, ST_IDLE);
    check("rst_mvld8", if8.m_vld, 0);
    check("rst_mdat8", if8.m_dat, 0);
    check("rst_srdy8", if8.s_rdy, 0);
    check("rst_gnt2", gnt2, 0);
    check("rst_busy2", busy2, 0);
    check("rst_mvld2", if2.m_vld, 0);
    check("rst_srdy2", if2.s_rdy, 0);

    // 1: single requester, 16 transfers in 18 cycles with one bubble
    sel = 1'b0;
    do_reset();
    for (int s = 0; s < 16; s++) exp_q.push_back(wd(0, s));
    mode  = 1;
    s_vld = 4'b0001;
    m_rdy = 1'b1;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      check("t1_gnt", cur_gnt, (k == 0 || k == 9) ? 0 : 1);
      next_cycle();
    end
    check("t1_xfers", n_xfer, 16);
    check("t1_q_empty", exp_q.size(), 0);
    mode = 0;

    // 2: all requesting, BURST=2, order 0,1,2,3,0
    sel = 1'b1;
    do_reset();
    for (int b = 0; b < 5; b++) begin
      exp_q.push_back(wd(b % 4, (b / 4) * 2));
      exp_q.push_back(wd(b % 4, (b / 4) * 2 + 1));
    end
    mode  = 1;
    s_vld = 4'b1111;
    m_rdy = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      check("t2_gnt", cur_gnt, (k % 3 == 0) ? 0 : (1 << ((k / 3) % 4)));
      next_cycle();
    end
    check("t2_xfers", n_xfer, 10);
    check("t2_q_empty", exp_q.size(), 0);
    mode = 0;

    // 3: source 1 drops vld after 3 words; source 2 gets a full fresh burst
    sel = 1'b0;
    do_reset();
    for (int s = 0; s < 3; s++) exp_q.push_back(wd(1, s));
    for (int s = 0; s < 8; s++) exp_q.push_back(wd(2, s));
    mode  = 1;
    m_rdy = 1'b1;
    for (int k = 0; k < 15; k++) begin
      s_vld = (k < 4) ? 4'b0110 : 4'b0100;
      @(negedge clk);
      if (k == 0 || k == 5 || k == 14) begin
        check("t3_gnt", cur_gnt, 0);
        check("t3_busy", cur_busy, 0);
      end else begin
        check("t3_gnt", cur_gnt, (k <= 4) ? 4'b0010 : 4'b0100);
        check("t3_busy", cur_busy, 1);
      end
      next_cycle();
    end
    check("t3_xfers", n_xfer, 11);
    check("t3_q_empty", exp_q.size(), 0);
    mode = 0;

    // 4: backpressure for 5 cycles mid-burst
    sel = 1'b0;
    do_reset();
    for (int s = 0; s < 8; s++) exp_q.push_back(wd(0, s));
    mode  = 1;
    s_vld = 4'b0011;
    for (int k = 0; k < 15; k++) begin
      m_rdy = (k >= 3 && k <= 7) ? 1'b0 : 1'b1;
      @(negedge clk);
      check("t4_gnt", cur_gnt, (k == 0 || k == 14) ? 0 : 1);
      if (k == 1) check("t4_srdy_go", cur_s_rdy, 4'b0001);
      if (k >= 3 && k <= 7) begin
        check("t4_hold_vld", cur_m_vld, 1);
        check("t4_hold_dat", cur_m_dat, wd(0, 2));
        check("t4_hold_srdy", cur_s_rdy, 0);
      end
      next_cycle();
    end
    check("t4_xfers", n_xfer, 8);
    check("t4_q_empty", exp_q.size(), 0);
    mode = 0;

    // 5: asynchronous reset mid-burst
    sel = 1'b0;
    do_reset();
    for (int s = 0; s < 4; s++) exp_q.push_back(wd(0, s));
    mode  = 1;
    s_vld = 4'b0011;
    m_rdy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t5_gnt", cur_gnt, (k == 0) ? 0 : 1);
      next_cycle();
    end
    check("t5_xfers", n_xfer, 4);
    check("t5_q_empty", exp_q.size(), 0);
    rst = 1'b1;
    #1;
    check("t5_async_gnt", cur_gnt, 0);
    check("t5_async_busy", cur_busy, 0);
    check("t5_async_mvld", cur_m_vld, 0);
    repeat (2) @(posedge clk);
    #1;
    m_rdy = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
    check("t5_post_idle", cur_gnt, 0);
    next_cycle();
    @(negedge clk);
    check("t5_post_gnt", cur_gnt, 4'b0001);
    check("t5_post_mvld", cur_m_vld, 1);
    check("t5_post_mdat", cur_m_dat, wd(0, 0));
    mode = 0;

    // 6: random vld / m_rdy on both instances
    for (int pass = 0; pass < 2; pass++) begin
      sel = (pass == 0);
      do_reset();
      mode = 2;
      for (int c = 0; c < 20000 && n_xfer < 1000; c++) begin
        s_vld = N'($urandom_range(0, (1 << N) - 1));
        m_rdy = 1'($urandom_range(0, 1));
        @(negedge clk);
        next_cycle();
      end
      check("t6_xfer_budget", n_xfer >= 1000, 1);
      mode = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
